debug_uart_arbiter: RTL
=======================

Name: debug_uart_arbiter

Overview:
Shares the single debug UART transmitter between two byte sources: CPU writes to the debug UART register, and a hardware trace source such as a register-dump streamer. CPU bytes are buffered in a small FIFO, so firmware no longer spins on the busy status for every byte. The block sits between the address-decode logic and the uart_tx instance, and drives that instance's enable/data inputs.

Parameters:
FIFO_DEPTH, 4, CPU byte FIFO entries; power of 2, minimum 2.
BUSY_WAIT, 2, max cycles to wait for tx_busy to rise after a launch before treating the byte as sent.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_wr  in  1  one-cycle strobe: push cpu_data (the decoded write to the debug UART address)
cpu_data  in  8  CPU byte (data_to_write[7:0])
cpu_full  out  1  FIFO full
cpu_empty  out  1  FIFO empty
cpu_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
cpu_ovf  out  1  sticky: a push was dropped
ovf_clr  in  1  clears cpu_ovf
trc_valid  in  1  trace byte offered
trc_data  in  8  trace byte
trc_ready  out  1  trace byte accepted this cycle (combinational)
tx_en  out  1  one-cycle launch pulse to uart_tx
tx_data  out  8  byte to uart_tx, registered
tx_busy  in  1  uart_tx busy
arb_busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: state=IDLE, FIFO empty, cpu_level=0, cpu_full=0, cpu_empty=1, cpu_ovf=0, tx_en=0, tx_data=0, trc_ready=0, last_grant=TRACE (so the CPU wins the first tie).
- Reset mid-transfer: abandons the arbiter state and flushes the FIFO. uart_tx is reset by the same reset, so no byte is re-sent.
- FIFO push:
  - Push occurs on cpu_wr when not full.
  - When full, the push is accepted only if a pop happens in the same cycle. Otherwise the byte is dropped and cpu_ovf sets.
  - Pop and push in the same cycle leave cpu_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- cpu_ovf: ovf_clr clears it. If ovf_clr coincides with a new drop, set wins.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE, when tx_busy=0 and at least one requester is ready:
  - Requesters are: CPU when FIFO non-empty; TRACE when trc_valid=1.
  - Grant is round-robin: if both request, grant the one not equal to last_grant.
  - CPU grant: pop the FIFO head into tx_data.
  - TRACE grant: drive trc_ready=1 this cycle and capture trc_data into tx_data.
  - Record last_grant; next state LAUNCH.
  - If tx_busy=1 in IDLE (e.g. the UART is still finishing a byte after reset release), no grant is made.
- LAUNCH: tx_en=1 for exactly one cycle, tx_data stable; next state WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - After BUSY_WAIT cycles without tx_busy -> IDLE.
- WAIT_DONE: wait for tx_busy=0, then IDLE.
- Throughput: the next launch can occur no earlier than 1 cycle after tx_busy falls (IDLE grant, then LAUNCH).
- trc_ready is never asserted outside IDLE. It is never asserted unless trc_valid=1.
- Width rules:
  - cpu_level counts 0..FIFO_DEPTH inclusive.
  - Pointers are $clog2(FIFO_DEPTH) bits, plus one wrap bit for full/empty.

Decomposition:
- Shared package (debug_uart_pkg): the state enum IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE, grant encodings CPU=0/TRACE=1, and the debug UART address constants.
- One sub-module, byte_fifo (parameter DEPTH): push/pop/full/empty/level.
- Arbiter FSM and round-robin logic stay in the top.

Test Plan:
1. Reset, then 3 cpu_wr of 0x41, 0x42, 0x43; uart model holds busy for 10 cycles per byte -> tx_en pulses 3 times with tx_data 0x41, 0x42, 0x43 in order; cpu_level goes 3->0; cpu_ovf=0.
2. With the uart held busy, 6 cpu_wr (0x10..0x15) at FIFO_DEPTH=4 -> cpu_full=1 after 4; 0x14 and 0x15 dropped; cpu_ovf=1. Then ovf_clr -> cpu_ovf=0. Sent bytes are 0x10..0x13 only.
3. Both requesters ready: FIFO holds 0xA0, 0xA1; trc_valid=1 with 0xB0, then 0xB1 -> transmit order 0xA0, 0xB0, 0xA1, 0xB1; trc_ready pulses once per accepted byte.
4. Full FIFO and cpu_wr in the same cycle as the IDLE grant pop -> push accepted; cpu_level stays 4; cpu_ovf stays 0.
5. Uart model never raises busy -> after LAUNCH, the FSM returns to IDLE after BUSY_WAIT=2 cycles; the next byte launches.
6. rst asserted during WAIT_DONE with 2 bytes queued -> next cycle: state IDLE, cpu_empty=1, tx_en=0, trc_ready=0; no further tx_en pulses until new pushes.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART arbiter and its neighbours.
package debug_uart_pkg;

  // Arbiter sequencing: pick a source, pulse the UART, then track its busy flag.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Which requester owned the most recent launch.
  typedef enum logic {
    CPU   = 1'b0,
    TRACE = 1'b1
  } grant_e;

  // Address-decode constants for the debug UART register block.
  localparam logic [31:0] DBG_UART_DATA_ADDR = 32'h0000_F000;
  localparam logic [31:0] DBG_UART_STAT_ADDR = 32'h0000_F004;

endpackage

// File: rtl/debug_uart_arbiter_if.sv
// Signal bundle between the address decode / trace source / uart_tx and the arbiter.
interface debug_uart_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // CPU write side
  logic          cpu_wr;
  logic [7:0]    cpu_data;
  logic          cpu_full;
  logic          cpu_empty;
  logic [LW-1:0] cpu_level;
  logic          cpu_ovf;
  logic          ovf_clr;
  // Trace source side
  logic          trc_valid;
  logic [7:0]    trc_data;
  logic          trc_ready;
  // uart_tx side
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  // Status
  logic          arb_busy;

  // Surrounding logic: decode, trace streamer and uart_tx.
  modport master (
    output cpu_wr, cpu_data, ovf_clr, trc_valid, trc_data, tx_busy,
    input  cpu_full, cpu_empty, cpu_level, cpu_ovf, trc_ready, tx_en, tx_data, arb_busy
  );

  // The arbiter itself.
  modport slave (
    input  cpu_wr, cpu_data, ovf_clr, trc_valid, trc_data, tx_busy,
    output cpu_full, cpu_empty, cpu_level, cpu_ovf, trc_ready, tx_en, tx_data, arb_busy
  );
endinterface

// File: rtl/debug_uart_arbiter_byte_fifo.sv
// Small byte FIFO for CPU writes. A push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle; push_ok reports acceptance.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   push_ok
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Accept/advance decisions for both pointers.
  always_comb begin
    do_pop   = pop && !empty;
    push_ok  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness comes from the pointers alone.
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/debug_uart_arbiter.sv
// Shares the debug uart_tx between buffered CPU writes and a trace byte source,
// with round-robin arbitration and a bounded wait for uart_tx to report busy.
module debug_uart_arbiter
  import debug_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_WAIT  = 2
) (
  input logic                 clk,
  input logic                 rst,
  debug_uart_arbiter_if.slave bus
);
  localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  grant_e     grant;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ovf_q, ovf_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       tx_en;
  logic       trc_ready;
  logic       cpu_req;
  logic       trc_req;

  logic       fifo_pop;
  logic       fifo_push_ok;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cpu_wr),
    .pop     (fifo_pop),
    .din     (bus.cpu_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .push_ok (fifo_push_ok)
  );

  assign cpu_req = !fifo_empty;
  assign trc_req = bus.trc_valid;

  // Arbiter next-state, grant and launch decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    wait_cnt_d   = wait_cnt_q;
    grant        = CPU;
    fifo_pop     = 1'b0;
    trc_ready    = 1'b0;
    tx_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.tx_busy && (cpu_req || trc_req)) begin
          if (cpu_req && trc_req) begin
            grant = (last_grant_q == CPU) ? TRACE : CPU;
          end else begin
            grant = cpu_req ? CPU : TRACE;
          end
          if (grant == CPU) begin
            fifo_pop  = 1'b1;
            tx_data_d = fifo_dout;
          end else begin
            trc_ready = 1'b1;
            tx_data_d = bus.trc_data;
          end
          last_grant_d = grant;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_en      = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == CW'(BUSY_WAIT - 1)) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow: a dropped push sets it and wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (bus.cpu_wr && !fifo_push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= TRACE;
      tx_data_q    <= '0;
      ovf_q        <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      ovf_q        <= ovf_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.cpu_full  = fifo_full;
  assign bus.cpu_empty = fifo_empty;
  assign bus.cpu_level = fifo_level;
  assign bus.cpu_ovf   = ovf_q;
  assign bus.trc_ready = trc_ready;
  assign bus.tx_en     = tx_en;
  assign bus.tx_data   = tx_data_q;
  assign bus.arb_busy  = (state_q != IDLE) || !fifo_empty;

endmodule
